mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX stage.
- Consumes the EX results: ALU result c, store data b, jump_or_branch and reg_wr_addr, plus opcode/funct3/pc passed along.
- Performs loads and stores over a req/ack data-memory bus, and drives the fetch redirect and the registered writeback bundle to the WB stage.
- Stalls upstream stages while a memory access is outstanding.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage sitting directly after EX.
//
// Takes the EX result bundle, runs loads/stores over a req/ack data bus,
// raises the fetch redirect for taken control transfers, and registers the
// writeback bundle for WB. Upstream is stalled while a bus access is pending.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   valid_in                   EX bundle valid this cycle
//   opcode, funct3, pc_in      instruction fields passed along from EX
//   c, b                       ALU result (address / target / value), store data
//   jump_or_branch             control transfer taken
//   reg_wr_addr                destination register
//   stall                      upstream must hold its outputs stable
//   redirect_valid/_pc         combinational fetch redirect
//   dmem_req/we/addr/wdata/strb  data bus request (combinational)
//   dmem_ack, dmem_rdata       data bus completion and read word
//   wb_valid/we/rd/data        registered writeback bundle
//   exc_misaligned, exc_bus    registered single-cycle exception pulses
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc_in,
  input  logic [31:0] c,
  input  logic [31:0] b,
  input  logic        jump_or_branch,
  input  logic [4:0]  reg_wr_addr,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misaligned,
  output logic        exc_bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // WAIT is entered with the counter at 1 after the first request cycle, so
  // the request has been up for cnt_q+1 cycles during a WAIT cycle. The last
  // allowed request cycle is therefore the one with cnt_q == TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << a;
      2'b01:   r = 4'b0011 << a;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Sub-word data is replicated across lanes; the strobes pick the live bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  by;
    logic [15:0] hw;
    logic [31:0] r;
    by = w[{a, 3'b000} +: 8];
    hw = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{by[7]}}, by};
      3'b001:  r = {{16{hw[15]}}, hw};
      3'b100:  r = {24'b0, by};
      3'b101:  r = {16'b0, hw};
      default: r = w;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_bus_q, exc_bus_d;

  logic v, is_load, is_store, is_mem, is_jump, is_ctrl, writes_rd, mis;
  logic req, done;

  always_comb begin
    // Valid is masked by reset so every combinational output is quiet then.
    v         = valid_in & rst_n;
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_mem    = is_load | is_store;
    is_jump   = (opcode == OP_JAL) | (opcode == OP_JALR);
    is_ctrl   = is_jump | (opcode == OP_BRANCH);
    writes_rd = is_load | is_jump | (opcode == OP_LUI) | (opcode == OP_AUIPC) |
                (opcode == OP_OP) | (opcode == OP_IMM);
    mis       = is_mem & is_misaligned(funct3, c[1:0]);

    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    exc_mis_d = 1'b0;
    exc_bus_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (v) begin
          if (is_mem && !mis) begin
            req = 1'b1;
            if (dmem_ack) begin
              done = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = S_WAIT;
              cnt_d   = 8'd1;
            end
          end else begin
            // Non-memory ops and misaligned accesses finish without the bus.
            done      = 1'b1;
            exc_mis_d = mis;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q >= CNT_LAST) begin
          done      = 1'b1;
          exc_bus_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = 8'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    dmem_req   = req;
    dmem_we    = req & is_store;
    dmem_addr  = req ? {c[31:2], 2'b00} : 32'd0;
    dmem_strb  = (req && is_store) ? store_strb(funct3, c[1:0]) : 4'b0000;
    dmem_wdata = (req && is_store) ? store_data(funct3, b) : 32'd0;

    redirect_valid = v & jump_or_branch & is_ctrl & ~stall;
    redirect_pc    = !v ? 32'd0 : (opcode == OP_JALR) ? {c[31:1], 1'b0} : c;

    wb_valid_d = done;
    wb_we_d    = done & writes_rd & (reg_wr_addr != 5'd0) & ~exc_mis_d & ~exc_bus_d;
    wb_rd_d    = done ? reg_wr_addr : 5'd0;
    wb_data_d  = 32'd0;
    if (done && !exc_mis_d && !exc_bus_d) begin
      if (is_load)      wb_data_d = load_extract(funct3, c[1:0], dmem_rdata);
      else if (is_jump) wb_data_d = pc_in + 32'd4;
      else              wb_data_d = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      exc_mis_q  <= exc_mis_d;
      exc_bus_q  <= exc_bus_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign exc_misaligned = exc_mis_q;
  assign exc_bus        = exc_bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed bench for mem_stage with an instruction-level model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, BRANCH = 7'b1100011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, OPR = 7'b0110011, OPI = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc_in, c, b;
  logic        jump_or_branch;
  logic [4:0]  reg_wr_addr;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_strb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misaligned, exc_bus;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .funct3(funct3),
    .pc_in(pc_in), .c(c), .b(b), .jump_or_branch(jump_or_branch),
    .reg_wr_addr(reg_wr_addr), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .exc_misaligned(exc_misaligned), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: request cycles already spent on the current memory instruction.
  int wait_cnt = 0;
  // Observations kept for the literal pin checks.
  logic        last_done;
  logic [31:0] last_wb_data, last_strb, last_wdata, last_rpc;
  logic        last_exc_bus, last_exc_mis, last_wb_we;
  int          req_seen, stall_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] cc, input logic [31:0] bb,
                       input logic jb, input logic [4:0] rd);
    valid_in = v; opcode = op; funct3 = f3; pc_in = pc; c = cc; b = bb;
    jump_or_branch = jb; reg_wr_addr = rd;
  endtask

  // One clock of the stage: check the combinational outputs against the model,
  // then the registered bundle after the edge. Called at a falling edge.
  task automatic step(input logic ack, input logic [31:0] rdata);
    logic is_ld, is_st, is_mem, is_jmp, is_ctl, wr, mis, req, done, ebus, emis, stl;
    int size;
    logic [31:0] word_sh, val, exp_wd;
    logic [3:0] exp_strb;
    dmem_ack = ack;
    dmem_rdata = rdata;
    #1;
    is_ld  = (opcode == LOAD);
    is_st  = (opcode == STORE);
    is_mem = is_ld || is_st;
    is_jmp = (opcode == JAL) || (opcode == JALR);
    is_ctl = is_jmp || (opcode == BRANCH);
    wr = is_ld || is_jmp || opcode inside {LUI, AUIPC, OPR, OPI};
    size = (funct3[1:0] == 2'd0) ? 1 : (funct3[1:0] == 2'd1) ? 2 : 4;
    mis = is_mem && ((c % size) != 0);
    req = 0; done = 0; ebus = 0; emis = 0;
    if (valid_in) begin
      if (is_mem && !mis) begin
        req = 1;
        if (ack) done = 1;
        else if (wait_cnt + 1 == TIMEOUT) begin done = 1; ebus = 1; end
      end else begin
        done = 1;
        emis = mis;
      end
    end
    stl = req && !done;
    chk("stall", stall, stl);
    chk("dmem_req", dmem_req, req);
    if (req) begin
      chk("dmem_addr", dmem_addr, c & ~32'd3);
      chk("dmem_we", dmem_we, is_st);
      exp_strb = is_st ? 4'(((1 << size) - 1) << (c % 4)) : 4'd0;
      chk("dmem_strb", dmem_strb, exp_strb);
      if (is_st) begin
        exp_wd = (size == 1) ? {4{b[7:0]}} : (size == 2) ? {2{b[15:0]}} : b;
        chk("dmem_wdata", dmem_wdata, exp_wd);
      end
    end
    if (dmem_req) req_seen++;
    if (stall) stall_seen++;
    last_strb = 32'(dmem_strb);
    last_wdata = dmem_wdata;
    chk("redirect_valid", redirect_valid, valid_in && jump_or_branch && is_ctl && !stl);
    if (redirect_valid) begin
      last_rpc = redirect_pc;
      chk("redirect_pc", redirect_pc, (opcode == JALR) ? (c & ~32'd1) : c);
    end
    // Expected writeback value from the instruction's meaning.
    word_sh = rdata >> (8 * (c % 4));
    case (funct3)
      3'b000:  val = 32'(signed'(word_sh[7:0]));
      3'b001:  val = 32'(signed'(word_sh[15:0]));
      3'b100:  val = {24'd0, word_sh[7:0]};
      3'b101:  val = {16'd0, word_sh[15:0]};
      default: val = rdata;
    endcase
    if (!is_ld) val = is_jmp ? pc_in + 4 : c;
    wait_cnt = (req && !done) ? wait_cnt + 1 : 0;

    @(posedge clk);
    #1;
    last_done = done;
    chk("wb_valid", wb_valid, done);
    chk("exc_misaligned", exc_misaligned, emis);
    chk("exc_bus", exc_bus, ebus);
    if (done) begin
      chk("wb_we", wb_we, wr && reg_wr_addr != 0 && !emis && !ebus);
      if (!emis && !ebus) begin
        chk("wb_rd", wb_rd, reg_wr_addr);
        chk("wb_data", wb_data, val);
      end
    end
    last_wb_data = wb_data;
    last_wb_we = wb_we;
    last_exc_bus = exc_bus;
    last_exc_mis = exc_misaligned;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with a load presented: nothing may leak out.
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    drive(1, LOAD, 3'b010, 32'h0, 32'h100, 32'h0, 0, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc", {exc_bus, exc_misaligned}, 0);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b1;

    // Idle cycle with a stray ack: ignored.
    step(1, 32'h1234_5678);

    // ALU op.
    drive(1, OPR, 3'b000, 32'h0, 32'h0000_0123, 32'h0, 0, 5'd5);
    stall_seen = 0;
    step(0, 0);
    chk("pin_alu_data", last_wb_data, 32'h0000_0123);
    chk("pin_alu_nostall", stall_seen, 0);

    // LB at 0x1003 with 3 wait cycles, then LBU of the same access.
    for (int k = 0; k < 2; k++) begin
      drive(1, LOAD, (k == 0) ? 3'b000 : 3'b100, 32'h0, 32'h1003, 32'h0, 0, 5'd7);
      stall_seen = 0;
      repeat (3) step(0, 0);
      step(1, 32'h80FF_FFFF);
      chk("pin_lb_stall", stall_seen, 3);
      chk("pin_lb_data", last_wb_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
    end

    // SH at 0x2002, immediate ack.
    drive(1, STORE, 3'b001, 32'h0, 32'h2002, 32'hABCD_1234, 0, 5'd0);
    stall_seen = 0;
    step(1, 0);
    chk("pin_sh_strb", last_strb, 32'hC);
    chk("pin_sh_wdata", last_wdata, 32'h1234_1234);
    chk("pin_sh_we", last_wb_we, 0);
    chk("pin_sh_nostall", stall_seen, 0);

    // SB lane and SW with one wait cycle, LH sign-extended, LHU upper half.
    drive(1, STORE, 3'b000, 32'h0, 32'h2001, 32'h0000_00A5, 0, 5'd0);
    step(1, 0);
    chk("pin_sb_strb", last_strb, 32'h2);
    drive(1, STORE, 3'b010, 32'h0, 32'h2004, 32'hCAFE_F00D, 0, 5'd0);
    step(0, 0);
    step(1, 0);
    drive(1, LOAD, 3'b001, 32'h0, 32'h3000, 32'h0, 0, 5'd9);
    step(1, 32'h1234_8001);
    chk("pin_lh_data", last_wb_data, 32'hFFFF_8001);
    drive(1, LOAD, 3'b101, 32'h0, 32'h3002, 32'h0, 0, 5'd9);
    step(1, 32'h9876_0000);

    // Misaligned LW and SH.
    drive(1, LOAD, 3'b010, 32'h0, 32'h3001, 32'h0, 0, 5'd4);
    req_seen = 0;
    step(1, 0);
    chk("pin_mis_exc", last_exc_mis, 1);
    chk("pin_mis_noreq", req_seen, 0);
    drive(1, STORE, 3'b001, 32'h0, 32'h3003, 32'h0, 0, 5'd0);
    step(0, 0);

    // Control transfers and misc ALU forms.
    drive(1, JALR, 3'b000, 32'h100, 32'h401, 32'h0, 1, 5'd1);
    step(0, 0);
    chk("pin_jalr_rpc", last_rpc, 32'h400);
    chk("pin_jalr_data", last_wb_data, 32'h104);
    drive(1, JAL, 3'b000, 32'h200, 32'h801, 32'h0, 1, 5'd2);
    step(0, 0);
    drive(1, BRANCH, 3'b001, 32'h300, 32'h900, 32'h0, 1, 5'd3);
    step(0, 0);
    drive(1, BRANCH, 3'b001, 32'h300, 32'h900, 32'h0, 0, 5'd3);
    step(0, 0);
    drive(1, LUI, 3'b000, 32'h0, 32'hABCD_E000, 32'h0, 0, 5'd0);
    step(0, 0);
    drive(1, AUIPC, 3'b000, 32'h0, 32'h0000_5000, 32'h0, 0, 5'd31);
    step(0, 0);

    // LW that never gets an ack: exactly TIMEOUT request cycles then exc_bus.
    drive(1, LOAD, 3'b010, 32'h0, 32'h4000, 32'h0, 0, 5'd6);
    req_seen = 0;
    last_done = 0;
    for (int i = 0; i < 40 && !last_done; i++) step(0, 0);
    chk("pin_to_done", last_done, 1);
    chk("pin_to_reqs", req_seen, 16);
    chk("pin_to_exc", last_exc_bus, 1);
    valid_in = 1'b0;
    step(0, 0);

    // Ack in the 16th request cycle wins.
    drive(1, LOAD, 3'b010, 32'h0, 32'h4004, 32'h0, 0, 5'd6);
    repeat (15) step(0, 0);
    step(1, 32'hDEAD_BEEF);
    chk("pin_ack16_data", last_wb_data, 32'hDEAD_BEEF);
    chk("pin_ack16_noexc", last_exc_bus, 0);

    // Reset in the middle of a wait.
    drive(1, LOAD, 3'b010, 32'h0, 32'h5000, 32'h0, 0, 5'd8);
    repeat (3) step(0, 0);
    chk("pre_rst_req", dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb", {wb_valid, wb_we, wb_rd, exc_bus, exc_misaligned}, 0);
    chk("midrst_wb_data", wb_data, 0);
    wait_cnt = 0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, OPI, 3'b000, 32'h0, 32'h0000_0042, 32'h0, 0, 5'd10);
    step(0, 0);
    chk("pin_post_rst", last_wb_data, 32'h0000_0042);
    valid_in = 1'b0;
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
